reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter-free widths from shared header: REG_POS_WID=5 bits, DATA_WID=32 bits, ROB_POS_WID=4 bits (ROB_SIZE 16).
REQ-002 clk  input  1  clock, all state updates on posedge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 rollback  input  1  flush pulse from reorder buffer.
REQ-006 decode  input  1  issue of an instruction that writes rd this cycle.
REQ-007 decode_rd  input  5  destination architectural register.
REQ-008 decode_rob_pos  input  4  reorder-buffer slot allocated to the issuing instruction.
REQ-009 decode_rs1 / decode_rs2  input  5 each  source register indices.
REQ-010 decode_rs1_val / decode_rs2_val  output  32 each  committed register value.
REQ-011 decode_rs1_busy / decode_rs2_busy  output  1 each  register awaits an in-flight producer.
REQ-012 decode_rs1_rob_pos / decode_rs2_rob_pos  output  4 each  slot of the youngest in-flight producer.
REQ-013 reg_commit, reg_commit_rd (5), reg_commit_val (32), reg_commit_rob_pos (4)  input  commit write port.

Function
REQ-014 SHALL hold 32x32-bit values, 32 busy bits, 32 4-bit producer tags.
REQ-015 Read ports SHALL be combinational, zero latency; x0 SHALL read val=0, busy=0, rob_pos=0 always.
REQ-016 Commit (rdy & reg_commit & rd!=0) SHALL write reg_commit_val into val[rd] at posedge.
REQ-017 Commit SHALL clear busy[rd] only when busy[rd]=1 and tag[rd]==reg_commit_rob_pos; otherwise busy/tag unchanged (younger producer pending).
REQ-018 Decode (rdy & decode & decode_rd!=0 & !rollback) SHALL set busy[rd]=1, tag[rd]=decode_rob_pos.
REQ-019 Decode and commit to same rd in same cycle: value written from commit; busy=1 and tag=decode_rob_pos from decode win.
REQ-020 Writes to x0 from either port SHALL be discarded.
REQ-021 Rollback cycle (rdy & rollback): all busy bits SHALL clear, tags to 0; a simultaneous commit value write SHALL still land; simultaneous decode SHALL be ignored.
REQ-022 rdy low SHALL suppress commit, decode and rollback effects; reads stay valid.

Reset
REQ-023 rst at posedge SHALL zero all values, busy bits and tags; overrides rdy, commit, decode, rollback.
REQ-024 After reset all read outputs SHALL be 0 for every index.

Configuration
REQ-025 Macro REG_FILE_COMMIT_FWD_EN: defined -> read port matching a same-cycle valid commit (rs==reg_commit_rd, rs!=0) SHALL output reg_commit_val, and busy=0 when REQ-017 clear condition holds.
REQ-026 Undefined -> read ports SHALL reflect stored state only; same-cycle commit visible next cycle.

Structure
REQ-027 REG_POS_WID, DATA_WID, ROB_POS_WID, ROB_SIZE SHALL come from the shared constants header cons.v; no local redefinition.
REQ-028 One sub-module reg_file_read_port (index -> val/busy/rob_pos incl. forwarding mux) SHALL be instantiated twice.

Verification
REQ-029 Reset then read x1..x31 -> val=0, busy=0, rob_pos=0.
REQ-030 Decode rd=5 pos=3; next cycle read rs1=5 -> busy=1, rob_pos=3; commit rd=5 pos=3 val=0xDEADBEEF -> next cycle busy=0, val=0xDEADBEEF.
REQ-031 Decode rd=7 pos=2, decode rd=7 pos=4, commit rd=7 pos=2 val=0x11 -> val=0x11, busy=1, rob_pos=4.
REQ-032 Same cycle decode rd=9 pos=6 and commit rd=9 pos=1 val=0x22 -> val=0x22, busy=1, rob_pos=6; decode/commit rd=0 -> x0 stays 0.
REQ-033 Three regs busy, rollback with commit rd=3 val=0x33 and decode rd=4 -> all busy=0, x3=0x33, x4 not busy.
REQ-034 With REG_FILE_COMMIT_FWD_EN, commit rd=8 pos=5 val=0x44 while rs2=8 busy tag 5 -> same cycle rs2_val=0x44, busy=0; without macro -> old value, busy=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file constants (mirrors the cons.v widths) plus a small write-qualify helper.
package reg_file_pkg;
   localparam int REG_POS_WID = 5;
   localparam int DATA_WID    = 32;
   localparam int ROB_SIZE    = 16;
   localparam int ROB_POS_WID = $clog2(ROB_SIZE);
   localparam int REG_NUM     = 1 << REG_POS_WID;

   typedef logic [REG_POS_WID-1:0] reg_pos_t;
   typedef logic [DATA_WID-1:0]    data_t;
   typedef logic [ROB_POS_WID-1:0] rob_pos_t;

   // x0 is hardwired, so any write aimed at it is dropped
   function automatic logic reg_write_ok(input logic en, input reg_pos_t rd);
      return en && (rd != '0);
   endfunction
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: index -> value/busy/producer tag.
// Optional same-cycle commit forwarding when REG_FILE_COMMIT_FWD_EN is defined.
module reg_file_read_port
   import reg_file_pkg::*;
(
   input  reg_pos_t                          rs,
   input  logic [REG_NUM-1:0][DATA_WID-1:0]    val_arr,
   input  logic [REG_NUM-1:0]                  busy_arr,
   input  logic [REG_NUM-1:0][ROB_POS_WID-1:0] tag_arr,
   input  logic                              commit_valid,
   input  reg_pos_t                          commit_rd,
   input  data_t                             commit_val,
   input  rob_pos_t                          commit_rob_pos,
   output data_t                             val,
   output logic                              busy,
   output rob_pos_t                          rob_pos
);
`ifdef REG_FILE_COMMIT_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   logic fwd_hit;
   logic tag_match;

   assign fwd_hit   = FWD_EN && commit_valid && (commit_rd == rs);
   assign tag_match = busy_arr[rs] && (tag_arr[rs] == commit_rob_pos);

   always_comb begin
      val     = val_arr[rs];
      busy    = busy_arr[rs];
      rob_pos = tag_arr[rs];
      if (fwd_hit) begin
         val  = commit_val;
         busy = busy_arr[rs] && !tag_match;
      end
      if (rs == '0) begin
         val     = '0;
         busy    = 1'b0;
         rob_pos = '0;
      end
   end
endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename busy bits and ROB producer tags.
// Commit forwarding on the read ports is enabled by defining REG_FILE_COMMIT_FWD_EN.
module reg_file
   import reg_file_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     rollback,
   input  logic     decode,
   input  reg_pos_t decode_rd,
   input  rob_pos_t decode_rob_pos,
   input  reg_pos_t decode_rs1,
   input  reg_pos_t decode_rs2,
   output data_t    decode_rs1_val,
   output data_t    decode_rs2_val,
   output logic     decode_rs1_busy,
   output logic     decode_rs2_busy,
   output rob_pos_t decode_rs1_rob_pos,
   output rob_pos_t decode_rs2_rob_pos,
   input  logic     reg_commit,
   input  reg_pos_t reg_commit_rd,
   input  data_t    reg_commit_val,
   input  rob_pos_t reg_commit_rob_pos
);
   logic [REG_NUM-1:0][DATA_WID-1:0]    val_reg;
   logic [REG_NUM-1:0]                  busy_reg;
   logic [REG_NUM-1:0][ROB_POS_WID-1:0] tag_reg;

   logic commit_valid;
   logic decode_valid;

   assign commit_valid = rdy && reg_write_ok(reg_commit, reg_commit_rd);
   assign decode_valid = rdy && !rollback && reg_write_ok(decode, decode_rd);

   // Statement order sets priority: rollback clears over commit, decode tag beats commit clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         val_reg  <= '0;
         busy_reg <= '0;
         tag_reg  <= '0;
      end else begin
         if (commit_valid) begin
            val_reg[reg_commit_rd] <= reg_commit_val;
            if (busy_reg[reg_commit_rd] && (tag_reg[reg_commit_rd] == reg_commit_rob_pos))
               busy_reg[reg_commit_rd] <= 1'b0;
         end
         if (rdy && rollback) begin
            busy_reg <= '0;
            tag_reg  <= '0;
         end else if (decode_valid) begin
            busy_reg[decode_rd] <= 1'b1;
            tag_reg[decode_rd]  <= decode_rob_pos;
         end
      end
   end

   reg_file_read_port u_rs1 (
      .rs             (decode_rs1),
      .val_arr        (val_reg),
      .busy_arr       (busy_reg),
      .tag_arr        (tag_reg),
      .commit_valid   (commit_valid),
      .commit_rd      (reg_commit_rd),
      .commit_val     (reg_commit_val),
      .commit_rob_pos (reg_commit_rob_pos),
      .val            (decode_rs1_val),
      .busy           (decode_rs1_busy),
      .rob_pos        (decode_rs1_rob_pos)
   );

   reg_file_read_port u_rs2 (
      .rs             (decode_rs2),
      .val_arr        (val_reg),
      .busy_arr       (busy_reg),
      .tag_arr        (tag_reg),
      .commit_valid   (commit_valid),
      .commit_rd      (reg_commit_rd),
      .commit_val     (reg_commit_val),
      .commit_rob_pos (reg_commit_rob_pos),
      .val            (decode_rs2_val),
      .busy           (decode_rs2_busy),
      .rob_pos        (decode_rs2_rob_pos)
   );
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_COMMIT_FWD_EN when set.
module tb_reg_file;
   logic        clk = 1'b0;
   logic        rst, rdy, rollback, decode, reg_commit;
   logic [4:0]  decode_rd, decode_rs1, decode_rs2, reg_commit_rd;
   logic [3:0]  decode_rob_pos, reg_commit_rob_pos;
   logic [31:0] reg_commit_val;
   logic [31:0] decode_rs1_val, decode_rs2_val;
   logic        decode_rs1_busy, decode_rs2_busy;
   logic [3:0]  decode_rs1_rob_pos, decode_rs2_rob_pos;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .rollback           (rollback),
      .decode             (decode),
      .decode_rd          (decode_rd),
      .decode_rob_pos     (decode_rob_pos),
      .decode_rs1         (decode_rs1),
      .decode_rs2         (decode_rs2),
      .decode_rs1_val     (decode_rs1_val),
      .decode_rs2_val     (decode_rs2_val),
      .decode_rs1_busy    (decode_rs1_busy),
      .decode_rs2_busy    (decode_rs2_busy),
      .decode_rs1_rob_pos (decode_rs1_rob_pos),
      .decode_rs2_rob_pos (decode_rs2_rob_pos),
      .reg_commit         (reg_commit),
      .reg_commit_rd      (reg_commit_rd),
      .reg_commit_val     (reg_commit_val),
      .reg_commit_rob_pos (reg_commit_rob_pos)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rollback = 0; decode = 0; reg_commit = 0;
   endtask

   task automatic rd1(input logic [4:0] idx, input logic [31:0] v, input logic b,
                      input logic [3:0] p, input string tag);
      decode_rs1 = idx;
      #1;
      check({tag, ".val"},  decode_rs1_val, v);
      check({tag, ".busy"}, {31'd0, decode_rs1_busy}, {31'd0, b});
      check({tag, ".pos"},  {28'd0, decode_rs1_rob_pos}, {28'd0, p});
   endtask

   initial begin
      rst = 1; rdy = 1; rollback = 0;
      decode = 1; decode_rd = 5'd2; decode_rob_pos = 4'd1;
      reg_commit = 1; reg_commit_rd = 5'd2; reg_commit_val = 32'hAAAA_5555; reg_commit_rob_pos = 4'd1;
      decode_rs1 = 0; decode_rs2 = 0;
      step(); step();
      rst = 0; idle();

      // reset state: every register reads zero on both ports
      for (int i = 1; i < 32; i++) begin
         decode_rs2 = 5'(i);
         rd1(5'(i), 32'd0, 1'b0, 4'd0, $sformatf("reset_x%0d", i));
         check("reset_rs2", decode_rs2_val | {31'd0, decode_rs2_busy} | {28'd0, decode_rs2_rob_pos}, 32'd0);
      end
      $display("txn reset sweep done");

      // decode then matching commit
      decode = 1; decode_rd = 5; decode_rob_pos = 3; step(); idle();
      rd1(5, 32'd0, 1'b1, 4'd3, "dec_x5");
      reg_commit = 1; reg_commit_rd = 5; reg_commit_rob_pos = 3; reg_commit_val = 32'hDEADBEEF;
      step(); idle();
      rd1(5, 32'hDEADBEEF, 1'b0, 4'd3, "commit_x5");
      $display("txn decode/commit x5");

      // stale commit must not clear younger producer
      decode = 1; decode_rd = 7; decode_rob_pos = 2; step();
      decode_rob_pos = 4; step(); idle();
      reg_commit = 1; reg_commit_rd = 7; reg_commit_rob_pos = 2; reg_commit_val = 32'h11;
      step(); idle();
      rd1(7, 32'h11, 1'b1, 4'd4, "stale_x7");
      $display("txn stale commit x7");

      // same-cycle decode and commit to x9, then writes to x0
      decode = 1; decode_rd = 9; decode_rob_pos = 6;
      reg_commit = 1; reg_commit_rd = 9; reg_commit_rob_pos = 1; reg_commit_val = 32'h22;
      step(); idle();
      rd1(9, 32'h22, 1'b1, 4'd6, "same_x9");
      decode = 1; decode_rd = 0; decode_rob_pos = 7;
      reg_commit = 1; reg_commit_rd = 0; reg_commit_rob_pos = 7; reg_commit_val = 32'h55;
      step(); idle();
      rd1(0, 32'd0, 1'b0, 4'd0, "x0");
      $display("txn same-cycle x9 and x0 writes");

      // rdy low freezes everything
      rdy = 0; rollback = 1;
      decode = 1; decode_rd = 10; decode_rob_pos = 9;
      reg_commit = 1; reg_commit_rd = 5; reg_commit_rob_pos = 3; reg_commit_val = 32'h99;
      step(); idle(); rdy = 1;
      rd1(5, 32'hDEADBEEF, 1'b0, 4'd3, "frz_x5");
      rd1(7, 32'h11, 1'b1, 4'd4, "frz_x7");
      rd1(10, 32'd0, 1'b0, 4'd0, "frz_x10");
      $display("txn rdy-low freeze");

      // rollback with concurrent commit and decode
      decode = 1; decode_rd = 3; decode_rob_pos = 1; step(); idle();
      rollback = 1;
      reg_commit = 1; reg_commit_rd = 3; reg_commit_rob_pos = 8; reg_commit_val = 32'h33;
      decode = 1; decode_rd = 4; decode_rob_pos = 2;
      step(); idle();
      rd1(3, 32'h33, 1'b0, 4'd0, "rb_x3");
      rd1(4, 32'd0, 1'b0, 4'd0, "rb_x4");
      rd1(7, 32'h11, 1'b0, 4'd0, "rb_x7");
      rd1(9, 32'h22, 1'b0, 4'd0, "rb_x9");
      $display("txn rollback");

      // same-cycle commit visibility on rs2
      decode = 1; decode_rd = 8; decode_rob_pos = 5; step(); idle();
      reg_commit = 1; reg_commit_rd = 8; reg_commit_rob_pos = 5; reg_commit_val = 32'h44;
      decode_rs2 = 8;
      #1;
`ifdef REG_FILE_COMMIT_FWD_EN
      check("fwd_rs2.val",  decode_rs2_val, 32'h44);
      check("fwd_rs2.busy", {31'd0, decode_rs2_busy}, 32'd0);
`else
      check("fwd_rs2.val",  decode_rs2_val, 32'd0);
      check("fwd_rs2.busy", {31'd0, decode_rs2_busy}, 32'd1);
`endif
      check("fwd_rs2.pos", {28'd0, decode_rs2_rob_pos}, 32'd5);
      step(); idle();
      rd1(8, 32'h44, 1'b0, 4'd5, "post_x8");
      $display("txn commit forwarding x8");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
